// File: rtl/stack_ctrl_if.sv
// rtl/stack_ctrl_if.sv - CPU request, SP register and stack memory signals of stack_ctrl
interface stack_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             req_push;
  logic             req_pop;
  logic [WIDTH-1:0] push_data;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] pop_data;
  logic             err_overflow;
  logic             err_underflow;
  logic [WIDTH-1:0] sp_val;
  logic             sp_push;
  logic             sp_pop;
  logic [WIDTH-1:0] sp_new_val;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_we;
  logic             mem_re;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_push, req_pop, push_data, sp_val, mem_rdata,
    output ready, done, pop_data, err_overflow, err_underflow,
           sp_push, sp_pop, sp_new_val, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output req_push, req_pop, push_data, sp_val, mem_rdata,
    input  ready, done, pop_data, err_overflow, err_underflow,
           sp_push, sp_pop, sp_new_val, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - push/pop sequencer for the SP register and stack data memory
module stack_ctrl #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] STACK_TOP   = 16'hFFFF,
  parameter logic [WIDTH-1:0] STACK_LIMIT = 16'hFF00,
  parameter int               MEM_LAT     = 1
) (
  input logic         clk,
  input logic         reset,
  stack_ctrl_if.slave bus
);

  localparam int               CNT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WIDTH-1:0] FULL_SP = STACK_LIMIT - 1'b1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP_ADDR,
    POP_WAIT,
    POP_DONE,
    ERR
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_ovf_q, err_ovf_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      pop_data_q <= '0;
      cnt_q      <= '0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      pop_data_q <= pop_data_d;
      cnt_q      <= cnt_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    data_d            = data_q;
    pop_data_d        = pop_data_q;
    cnt_d             = cnt_q;
    err_ovf_d         = err_ovf_q;
    bus.ready         = 1'b0;
    bus.done          = 1'b0;
    bus.err_overflow  = 1'b0;
    bus.err_underflow = 1'b0;
    bus.sp_push       = 1'b0;
    bus.sp_pop        = 1'b0;
    bus.sp_new_val    = bus.sp_val;
    bus.mem_addr      = bus.sp_val;
    bus.mem_wdata     = data_q;
    bus.mem_we        = 1'b0;
    bus.mem_re        = 1'b0;

    case (state_q)
      IDLE: begin
        bus.ready = 1'b1;
        // Pop has priority; a simultaneous push is simply dropped.
        if (bus.req_pop) begin
          if (bus.sp_val == STACK_TOP) begin
            err_ovf_d = 1'b0;
            state_d   = ERR;
          end else begin
            state_d   = POP_ADDR;
          end
        end else if (bus.req_push) begin
          if (bus.sp_val == FULL_SP) begin
            err_ovf_d = 1'b1;
            state_d   = ERR;
          end else begin
            data_d    = bus.push_data;
            state_d   = PUSH;
          end
        end
      end

      PUSH: begin
        bus.mem_we     = 1'b1;
        bus.mem_addr   = bus.sp_val;
        bus.sp_push    = 1'b1;
        bus.sp_new_val = bus.sp_val - 1'b1;
        bus.done       = 1'b1;
        state_d        = IDLE;
      end

      POP_ADDR: begin
        // sp_val still holds the pre-pop pointer here; the top item sits one above it.
        bus.mem_re     = 1'b1;
        bus.mem_addr   = bus.sp_val + 1'b1;
        bus.sp_pop     = 1'b1;
        bus.sp_new_val = bus.sp_val + 1'b1;
        cnt_d          = CNT_INIT;
        state_d        = POP_WAIT;
      end

      POP_WAIT: begin
        if (cnt_q == '0) begin
          pop_data_d = bus.mem_rdata;
          state_d    = POP_DONE;
        end else begin
          cnt_d      = cnt_q - 1'b1;
        end
      end

      POP_DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end

      ERR: begin
        bus.done          = 1'b1;
        bus.err_overflow  = err_ovf_q;
        bus.err_underflow = !err_ovf_q;
        state_d           = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.pop_data = pop_data_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - randomized bench for stack_ctrl at MEM_LAT 1 and 3 against a stack model
module tb_stack_ctrl;

  localparam logic [15:0] TOP   = 16'hFFFF;
  localparam logic [15:0] LIMIT = 16'hFF00;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  stack_ctrl_if #(.WIDTH(16)) bus0 ();
  stack_ctrl_if #(.WIDTH(16)) bus1 ();

  stack_ctrl #(.WIDTH(16), .STACK_TOP(TOP), .STACK_LIMIT(LIMIT), .MEM_LAT(1))
    dut_l1 (.clk(clk), .reset(resetn), .bus(bus0));
  stack_ctrl #(.WIDTH(16), .STACK_TOP(TOP), .STACK_LIMIT(LIMIT), .MEM_LAT(3))
    dut_l3 (.clk(clk), .reset(resetn), .bus(bus1));

  logic [1:0]  req_push, req_pop, sp_load;
  logic [15:0] push_data [2];
  logic [15:0] sp_load_val [2];
  logic [1:0]  rdy, dn, eovf, eund, spp, spo, we, re;
  logic [15:0] popd [2];
  logic [15:0] snv [2];
  logic [15:0] addr [2];
  logic [15:0] wdata [2];
  logic [15:0] sp_reg [2];
  logic [15:0] rd_pipe [2][3];
  logic [15:0] env_mem [2][65536];
  int          both_strobes;

  assign bus0.req_push  = req_push[0];
  assign bus0.req_pop   = req_pop[0];
  assign bus0.push_data = push_data[0];
  assign bus0.sp_val    = sp_reg[0];
  assign bus0.mem_rdata = rd_pipe[0][0];
  assign bus1.req_push  = req_push[1];
  assign bus1.req_pop   = req_pop[1];
  assign bus1.push_data = push_data[1];
  assign bus1.sp_val    = sp_reg[1];
  assign bus1.mem_rdata = rd_pipe[1][2];

  assign rdy  = {bus1.ready, bus0.ready};
  assign dn   = {bus1.done, bus0.done};
  assign eovf = {bus1.err_overflow, bus0.err_overflow};
  assign eund = {bus1.err_underflow, bus0.err_underflow};
  assign spp  = {bus1.sp_push, bus0.sp_push};
  assign spo  = {bus1.sp_pop, bus0.sp_pop};
  assign we   = {bus1.mem_we, bus0.mem_we};
  assign re   = {bus1.mem_re, bus0.mem_re};
  assign popd[0]  = bus0.pop_data;
  assign popd[1]  = bus1.pop_data;
  assign snv[0]   = bus0.sp_new_val;
  assign snv[1]   = bus1.sp_new_val;
  assign addr[0]  = bus0.mem_addr;
  assign addr[1]  = bus1.mem_addr;
  assign wdata[0] = bus0.mem_wdata;
  assign wdata[1] = bus1.mem_wdata;

  // SP register and synchronous memory with a read pipeline; stale stages carry noise.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetn)            sp_reg[i] <= TOP;
      else if (sp_load[i])    sp_reg[i] <= sp_load_val[i];
      else if (spp[i] || spo[i]) sp_reg[i] <= snv[i];
      if (spp[i] && spo[i])   both_strobes <= both_strobes + 1;
      if (we[i])              env_mem[i][addr[i]] <= wdata[i];
      rd_pipe[i][0] <= re[i] ? env_mem[i][addr[i]] : 16'($urandom);
      rd_pipe[i][1] <= rd_pipe[i][0];
      rd_pipe[i][2] <= rd_pipe[i][1];
    end
  end

  // Reference: abstract stack state per instance.
  logic [15:0] ref_sp [2];
  logic [15:0] ref_mem [2][65536];
  bit          ref_valid [2][65536];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic set_sp(input int i, input logic [15:0] v);
    @(negedge clk);
    sp_load_val[i] = v;
    sp_load[i]     = 1'b1;
    @(posedge clk);
    #1 sp_load[i]  = 1'b0;
    ref_sp[i]      = v;
  endtask

  task automatic run_op(input int i, input bit do_push, input bit do_pop,
                        input logic [15:0] d, input bit hold);
    logic [15:0] sp0, exp_popd, got_addr, got_wdata, got_snv;
    bit          exp_uf, exp_of, pop_ok, push_ok, known;
    int          exp_lat, cycles, n_we, n_re, n_spp, n_spo, n_eo, n_eu, waited;
    logic        saw_done;

    sp0      = ref_sp[i];
    exp_uf   = do_pop && (sp0 == TOP);
    exp_of   = !do_pop && do_push && (sp0 == LIMIT - 16'd1);
    pop_ok   = do_pop && !exp_uf;
    push_ok  = !do_pop && do_push && !exp_of;
    known    = 1'b0;
    exp_lat  = 1;
    exp_popd = popd[i];
    if (pop_ok) begin
      ref_sp[i] = sp0 + 16'd1;
      known     = ref_valid[i][ref_sp[i]];
      exp_lat   = 2 + lat_of(i);
      if (known) exp_popd = ref_mem[i][ref_sp[i]];
    end else if (push_ok) begin
      ref_mem[i][sp0]   = d;
      ref_valid[i][sp0] = 1'b1;
      ref_sp[i]         = sp0 - 16'd1;
    end

    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!rdy[i] && waited < 20);
    if (!rdy[i]) check("ready_timeout", {31'd0, rdy[i]}, 32'd1);

    req_push[i]  = do_push;
    req_pop[i]   = do_pop;
    push_data[i] = d;
    @(posedge clk);
    #1;
    if (!hold) begin
      req_push[i] = 1'b0;
      req_pop[i]  = 1'b0;
    end

    cycles = 0; n_we = 0; n_re = 0; n_spp = 0; n_spo = 0; n_eo = 0; n_eu = 0;
    got_addr = '0; got_wdata = '0; got_snv = '0; saw_done = 1'b0;
    while (!saw_done && cycles < 12) begin
      @(negedge clk);
      cycles++;
      n_we  += int'(we[i]);
      n_re  += int'(re[i]);
      n_spp += int'(spp[i]);
      n_spo += int'(spo[i]);
      n_eo  += int'(eovf[i]);
      n_eu  += int'(eund[i]);
      if (we[i] || re[i]) begin
        got_addr  = addr[i];
        got_wdata = wdata[i];
      end
      if (spp[i] || spo[i]) got_snv = snv[i];
      saw_done = dn[i];
    end
    req_push[i] = 1'b0;
    req_pop[i]  = 1'b0;

    check("latency", cycles, exp_lat);
    check("err_overflow", n_eo, {31'd0, exp_of});
    check("err_underflow", n_eu, {31'd0, exp_uf});
    check("mem_we_count", n_we, {31'd0, push_ok});
    check("mem_re_count", n_re, {31'd0, pop_ok});
    check("sp_push_count", n_spp, {31'd0, push_ok});
    check("sp_pop_count", n_spo, {31'd0, pop_ok});
    if (known || !pop_ok) check("pop_data", popd[i], exp_popd);
    if (push_ok) begin
      check("push_addr", got_addr, sp0);
      check("push_wdata", got_wdata, d);
      check("push_sp_new", got_snv, sp0 - 16'd1);
    end
    if (pop_ok) begin
      check("pop_addr", got_addr, sp0 + 16'd1);
      check("pop_sp_new", got_snv, sp0 + 16'd1);
    end

    @(negedge clk);
    check("sp_after", sp_reg[i], ref_sp[i]);
    check("ready_after", {31'd0, rdy[i]}, 32'd1);
    if (push_ok) check("mem_content", env_mem[i][sp0], d);
  endtask

  initial begin
    int r;
    both_strobes = 0;
    resetn   = 1'b0;
    req_push = '0;
    req_pop  = '0;
    sp_load  = '0;
    for (int i = 0; i < 2; i++) begin
      push_data[i]   = '0;
      sp_load_val[i] = '0;
      ref_sp[i]      = TOP;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      check("rst_ready", {31'd0, rdy[i]}, 32'd1);
      check("rst_done", {31'd0, dn[i]}, 32'd0);
      check("rst_pop_data", popd[i], 16'h0000);
      check("rst_strobes", {28'd0, spp[i], spo[i], we[i], re[i]}, 32'd0);
      check("rst_sp", sp_reg[i], TOP);
    end

    for (int i = 0; i < 2; i++) begin
      run_op(i, 1'b0, 1'b1, 16'h0000, 1'b0);
      run_op(i, 1'b1, 1'b0, 16'h1234, 1'b0);
      run_op(i, 1'b0, 1'b1, 16'h0000, 1'b0);
      check("pop_1234", popd[i], 16'h1234);
      set_sp(i, 16'hFEFF);
      run_op(i, 1'b1, 1'b0, 16'h5555, 1'b0);
      set_sp(i, 16'hFF00);
      run_op(i, 1'b1, 1'b0, 16'h5555, 1'b0);
      set_sp(i, 16'hFFFE);
      run_op(i, 1'b1, 1'b0, 16'hABCD, 1'b0);
      run_op(i, 1'b1, 1'b1, 16'h7777, 1'b1);
      check("both_pop_value", popd[i], 16'hABCD);
    end

    for (int i = 0; i < 2; i++) begin
      set_sp(i, (i == 0) ? 16'hFF03 : 16'hFFFC);
      for (int k = 0; k < 150; k++) begin
        r = $urandom_range(0, 9);
        run_op(i, (r < 4) || (r >= 8), r >= 4, 16'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    // Reset while instance 1 is waiting on its memory read.
    set_sp(1, 16'hFFF0);
    @(negedge clk);
    req_pop[1] = 1'b1;
    @(posedge clk);
    #1 req_pop[1] = 1'b0;
    @(negedge clk);
    check("abort_pop_started", {31'd0, re[1]}, 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("abort_ready", {31'd0, rdy[1]}, 32'd1);
    check("abort_mem_re", {31'd0, re[1]}, 32'd0);
    check("abort_pop_data", popd[1], 16'h0000);
    check("abort_pop_data_l1", popd[0], 16'h0000);
    r = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      r += int'(dn[1]) + int'(re[1]) + int'(spo[1]) + int'(spp[1]) + int'(we[1]);
    end
    check("abort_no_activity", r, 0);
    check("abort_sp", sp_reg[1], TOP);

    check("sp_strobe_exclusive", both_strobes, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequences the stack-pointer register and data memory for PUSH and POP operations requested by the CPU control unit.
- Computes the new SP value and drives the SP register's push/pop/new_val inputs.
- Issues the matching data-memory write or read.
- Detects stack overflow and underflow, and reports completion with a one-cycle done pulse.

Parameters:
- WIDTH, 16, data/address width.
- STACK_TOP, 16'hFFFF, SP value when the stack is empty; the SP register reset value.
- STACK_LIMIT, 16'hFF00, lowest writable stack address.
- MEM_LAT, 1, data-memory read latency in cycles (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_push  in  1  push request, sampled only while ready=1.
- req_pop  in  1  pop request, sampled only while ready=1.
- push_data  in  WIDTH  value to push, latched on acceptance.
- ready  out  1  controller idle, can accept a request.
- done  out  1  one-cycle pulse when an operation completes (success or error).
- pop_data  out  WIDTH  last popped value, registered, held until the next successful pop.
- err_overflow  out  1  pulse with done: push rejected, stack full.
- err_underflow  out  1  pulse with done: pop rejected, stack empty.
- sp_val  in  WIDTH  current SP register output.
- sp_push  out  1  SP register push strobe.
- sp_pop  out  1  SP register pop strobe.
- sp_new_val  out  WIDTH  value loaded into SP on a strobe.
- mem_addr  out  WIDTH  stack memory address.
- mem_wdata  out  WIDTH  stack memory write data.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_rdata  in  WIDTH  memory read data, valid MEM_LAT cycles after mem_re.

Behaviour:
- Convention: SP points to the next free slot.
  - Empty: sp_val==STACK_TOP.
  - Full: sp_val==STACK_LIMIT-1.
  - Push: write mem[sp], then SP<=sp-1.
  - Pop: SP<=sp+1, then read mem[sp+1].
- SP arithmetic is modulo 2^WIDTH. Overflow and underflow checks prevent wrap in legal use.
- Reset (reset==0 at a rising edge):
  - state<=IDLE; pop_data<=0; wait counter<=0.
  - done, err_*, sp_push, sp_pop, mem_we and mem_re are all 0.
  - ready=1 from the first cycle after reset releases.
  - Reset mid-operation aborts the operation; no further strobes are issued.
  - The SP register is reset by its own reset; this block never drives it.
- States: IDLE, PUSH, POP_ADDR, POP_WAIT, POP_DONE, ERR.
- IDLE:
  - ready=1, all strobes 0.
  - req_pop=1 with sp_val==STACK_TOP -> ERR (underflow).
  - req_pop=1 otherwise -> POP_ADDR.
  - else req_push=1 with sp_val==STACK_LIMIT-1 -> ERR (overflow).
  - else req_push=1 -> PUSH, latching push_data.
  - Pop wins over push when both are high; the push is dropped and not queued.
- PUSH (1 cycle):
  - mem_we=1, mem_addr=sp_val, mem_wdata=latched data.
  - sp_push=1, sp_new_val=sp_val-1, done=1.
  - -> IDLE.
- POP_ADDR (1 cycle):
  - mem_re=1, mem_addr=sp_val+1.
  - sp_pop=1, sp_new_val=sp_val+1.
  - Load wait counter with MEM_LAT-1; -> POP_WAIT.
- POP_WAIT:
  - Counter decrements each cycle.
  - When counter==0, pop_data<=mem_rdata at the edge; -> POP_DONE.
- POP_DONE (1 cycle): done=1, pop_data valid; -> IDLE.
- ERR (1 cycle):
  - done=1, plus err_overflow or err_underflow.
  - No memory access, no SP strobe; pop_data unchanged.
  - -> IDLE.
- Latency, with acceptance at edge N:
  - Push done in cycle N+1.
  - Pop done in cycle N+2+MEM_LAT.
  - Error done in cycle N+1.
  - Back-to-back operations: a new request can be accepted at the edge ending the done cycle.
- ready, done, err_*, strobes and memory controls are combinational from state (plus sp_val for addresses). sp_push and sp_pop are never high together.

Test Plan:
1. Reset (reset=0 for 2 cycles) with sp_val=FFFF -> ready=1, done=0, pop_data=0000, no strobes. req_pop -> err_underflow=1, done=1 one cycle later, no mem_re or sp_pop.
2. Push 1234 with sp_val=FFFF -> next cycle mem_we=1, mem_addr=FFFF, mem_wdata=1234, sp_push=1, sp_new_val=FFFE, done=1; then ready=1.
3. With sp_val=FFFE and memory model mem[FFFF]=1234 at MEM_LAT=1 -> pop: mem_re=1, mem_addr=FFFF, sp_pop=1, sp_new_val=FFFF; done and pop_data=1234 three cycles after acceptance. Repeat at MEM_LAT=3 -> done after five cycles.
4. sp_val=FEFF (STACK_LIMIT-1), push 5555 -> err_overflow=1 with done, mem_we=0, sp_push=0. sp_val=FF00, push -> normal write to FF00, sp_new_val=FEFF.
5. req_push and req_pop both high with sp_val=FFFD -> pop only (mem_addr=FFFE, sp_pop=1), no mem_we. Requests held high while busy are ignored until ready=1.
6. Assert reset during POP_WAIT -> next cycle IDLE, mem_re=0, done never pulses, pop_data=0000.
